// File: rtl/exec_commit_unit.sv
// Execute/commit back end: runs the decoded ALU/compare/shift operation, drives
// the req/ack data-memory port, resolves branch redirects and issues write-back.
module exec_commit_unit #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  input  logic [31:0] cal_A,
  input  logic [31:0] cal_B,
  input  logic [4:0]  mode,
  input  logic        cal,
  input  logic        cmp,
  input  logic        cmp_signed,
  input  logic        load,
  input  logic        store,
  input  logic        jump,
  input  logic        lui,
  input  logic        write_reg,
  input  logic [4:0]  reg_address,
  input  logic [31:0] reg_data,
  input  logic [31:0] mem_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic        mem_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXE = 2'd1, MEM = 2'd2} state_t;

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] m);
    logic [31:0] r;
    r = 32'd0;
    case (m[4:3])
      2'b00: r = m[0] ? (a - b) : (a + b);
      2'b01: begin
        case (m[2:1])
          2'b00:   r = a >> b[4:0];
          2'b01:   r = a << b[4:0];
          2'b10:   r = $unsigned($signed(a) >>> b[4:0]);
          default: r = 32'd0;
        endcase
      end
      2'b10: begin
        case (m[2:1])
          2'b00:   r = a & b;
          2'b01:   r = a | b;
          2'b10:   r = a ^ b;
          default: r = ~(a | b);
        endcase
      end
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  state_t      state_r, state_s;
  logic [31:0] a_r, b_r, reg_data_r, mem_data_r;
  logic [4:0]  mode_r, reg_address_r;
  logic        cal_r, cmp_r, cmp_signed_r, load_r, store_r, jump_r, lui_r, write_reg_r;
  logic [7:0]  cnt_r, cnt_s;
  logic        in_ready_r, in_ready_s;
  logic        mem_req_r, mem_req_s, mem_we_r, mem_we_s, mem_err_r, mem_err_s;
  logic [31:0] mem_addr_r, mem_addr_s, mem_wdata_r, mem_wdata_s;
  logic        wb_en_r, wb_en_s, br_taken_r, br_taken_s;
  logic [4:0]  wb_addr_r, wb_addr_s;
  logic [31:0] wb_data_r, wb_data_s, br_target_r, br_target_s;
  logic [31:0] sum_s, result_s;
  logic        capture_s;

  // Result of the captured bundle, valid while in EXE.
  always_comb begin
    sum_s = a_r + b_r;
    if (lui_r) begin
      result_s = reg_data_r;
    end else if (cmp_r) begin
      result_s = {31'd0, (a_r < b_r)};
    end else if (cmp_signed_r) begin
      result_s = {31'd0, ($signed(a_r) < $signed(b_r))};
    end else if (cal_r) begin
      result_s = alu_f(a_r, b_r, mode_r);
    end else begin
      result_s = reg_data_r;
    end
  end

  // Next-state and next-output logic; strobes default low, other outputs hold.
  always_comb begin
    state_s     = state_r;
    capture_s   = 1'b0;
    cnt_s       = cnt_r;
    mem_req_s   = mem_req_r;
    mem_we_s    = mem_we_r;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    mem_err_s   = mem_err_r;
    wb_en_s     = 1'b0;
    wb_addr_s   = wb_addr_r;
    wb_data_s   = wb_data_r;
    br_taken_s  = 1'b0;
    br_target_s = br_target_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          capture_s = 1'b1;
          state_s   = EXE;
        end else begin
          state_s = IDLE;
        end
      end
      EXE: begin
        state_s = IDLE;
        if (flush) begin
          state_s = IDLE;
        end else if (load_r || store_r) begin
          if (sum_s[1:0] != 2'b00) begin
            mem_err_s = 1'b1;
          end else begin
            mem_req_s   = 1'b1;
            mem_we_s    = store_r;
            mem_addr_s  = sum_s;
            mem_wdata_s = mem_data_r;
            cnt_s       = 8'd0;
            state_s     = MEM;
          end
        end else if (jump_r) begin
          br_taken_s  = 1'b1;
          br_target_s = sum_s;
        end else if (write_reg_r && (reg_address_r != 5'd0)) begin
          wb_en_s   = 1'b1;
          wb_addr_s = reg_address_r;
          wb_data_s = result_s;
        end else begin
          state_s = IDLE;
        end
      end
      MEM: begin
        cnt_s = cnt_r + 8'd1;
        if (mem_ack) begin
          mem_req_s = 1'b0;
          state_s   = IDLE;
          if (load_r && (reg_address_r != 5'd0)) begin
            wb_en_s   = 1'b1;
            wb_addr_s = reg_address_r;
            wb_data_s = mem_rdata;
          end else begin
            wb_en_s = 1'b0;
          end
        end else if (cnt_r == TMO_LAST) begin
          mem_req_s = 1'b0;
          mem_err_s = 1'b1;
          state_s   = IDLE;
        end else begin
          state_s = MEM;
        end
      end
      default: state_s = IDLE;
    endcase
    in_ready_s = (state_s == IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= 8'd0;
      in_ready_r  <= 1'b1;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_wdata_r <= 32'd0;
      mem_err_r   <= 1'b0;
      wb_en_r     <= 1'b0;
      wb_addr_r   <= 5'd0;
      wb_data_r   <= 32'd0;
      br_taken_r  <= 1'b0;
      br_target_r <= 32'd0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      in_ready_r  <= in_ready_s;
      mem_req_r   <= mem_req_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      mem_err_r   <= mem_err_s;
      wb_en_r     <= wb_en_s;
      wb_addr_r   <= wb_addr_s;
      wb_data_r   <= wb_data_s;
      br_taken_r  <= br_taken_s;
      br_target_r <= br_target_s;
    end
  end

  // Bundle capture register, loaded on the accept handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= 32'd0; b_r <= 32'd0; mode_r <= 5'd0;
      reg_address_r <= 5'd0; reg_data_r <= 32'd0; mem_data_r <= 32'd0;
      cal_r <= 1'b0; cmp_r <= 1'b0; cmp_signed_r <= 1'b0; load_r <= 1'b0;
      store_r <= 1'b0; jump_r <= 1'b0; lui_r <= 1'b0; write_reg_r <= 1'b0;
    end else if (capture_s) begin
      a_r <= cal_A; b_r <= cal_B; mode_r <= mode;
      reg_address_r <= reg_address; reg_data_r <= reg_data; mem_data_r <= mem_data;
      cal_r <= cal; cmp_r <= cmp; cmp_signed_r <= cmp_signed; load_r <= load;
      store_r <= store; jump_r <= jump; lui_r <= lui; write_reg_r <= write_reg;
    end else begin
      a_r <= a_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_err   = mem_err_r;
  assign wb_en     = wb_en_r;
  assign wb_addr   = wb_addr_r;
  assign wb_data   = wb_data_r;
  assign br_taken  = br_taken_r;
  assign br_target = br_target_r;

endmodule

// File: tb/tb_exec_commit_unit.sv
// Directed plus randomized bench for exec_commit_unit against a spec-level model.
module tb_exec_commit_unit;
  localparam int TMO = 8;
  localparam logic [7:0] F_CAL = 8'h80, F_CMP = 8'h40, F_CMPS = 8'h20, F_LD = 8'h10,
                         F_ST = 8'h08, F_JMP = 8'h04, F_LUI = 8'h02, F_WR = 8'h01;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, flush = 1'b0, in_ready;
  logic [31:0] cal_A = 32'd0, cal_B = 32'd0, reg_data = 32'd0, mem_data = 32'd0;
  logic [4:0] mode = 5'd0, reg_address = 5'd0;
  logic cal = 1'b0, cmp = 1'b0, cmp_signed = 1'b0, load = 1'b0, store = 1'b0;
  logic jump = 1'b0, lui = 1'b0, write_reg = 1'b0;
  logic mem_req, mem_we, mem_ack = 1'b0, wb_en, br_taken, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 32'd0, wb_data, br_target;
  logic [4:0] wb_addr;

  int errors = 0, checks = 0;
  bit exp_err = 1'b0;

  always #5 clk = ~clk;

  exec_commit_unit #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .cal_A(cal_A), .cal_B(cal_B), .mode(mode), .cal(cal), .cmp(cmp),
    .cmp_signed(cmp_signed), .load(load), .store(store), .jump(jump), .lui(lui),
    .write_reg(write_reg), .reg_address(reg_address), .reg_data(reg_data),
    .mem_data(mem_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .br_taken(br_taken), .br_target(br_target),
    .mem_err(mem_err));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference result straight from the operation table.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] m, input logic [7:0] f,
                                        input logic [31:0] rd);
    int sh;
    sh = int'(b % 32);
    if ((f & F_LUI) != 8'd0) return rd;
    if ((f & F_CMP) != 8'd0) return (a < b) ? 32'd1 : 32'd0;
    if ((f & F_CMPS) != 8'd0) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    if ((f & F_CAL) == 8'd0) return rd;
    case (m)
      5'b00000, 5'b00010, 5'b00100, 5'b00110: return a + b;
      5'b00001, 5'b00011, 5'b00101, 5'b00111: return a - b;
      5'b01000, 5'b01001: return a >> sh;
      5'b01010, 5'b01011: return a << sh;
      5'b01100, 5'b01101: return (a >> sh) | ((a[31] && sh != 0) ? ~(32'hFFFFFFFF >> sh) : 32'd0);
      5'b10000, 5'b10001: return a & b;
      5'b10010, 5'b10011: return a | b;
      5'b10100, 5'b10101: return a ^ b;
      5'b10110, 5'b10111: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  // One complete bundle: drive, then check every strobe against the model.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] m, input logic [7:0] f, input logic [4:0] ra,
                       input logic [31:0] rd, input logic [31:0] md, input int ack_wait,
                       input bit fl_exe);
    logic [31:0] addr, res, rdv;
    bit is_mem, is_ld;
    int n;
    addr = a + b;
    res = model(a, b, m, f, rd);
    is_ld = (f & F_LD) != 8'd0;
    is_mem = is_ld || ((f & F_ST) != 8'd0);
    rdv = $urandom();
    @(negedge clk);
    check({tag, " ready"}, {31'd0, in_ready}, 32'd1);
    cal_A = a; cal_B = b; mode = m; reg_address = ra; reg_data = rd; mem_data = md;
    {cal, cmp, cmp_signed, load, store, jump, lui, write_reg} = f;
    in_valid = 1'b1;
    mem_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
    in_valid = 1'b0; mem_ack = 1'b0; flush = fl_exe;
    check({tag, " busy"}, {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    if (fl_exe) begin
      check({tag, " fl wb"}, {31'd0, wb_en}, 32'd0);
      check({tag, " fl br"}, {31'd0, br_taken}, 32'd0);
      check({tag, " fl req"}, {31'd0, mem_req}, 32'd0);
    end else if (is_mem && addr[1:0] != 2'b00) begin
      exp_err = 1'b1;
      check({tag, " unal req"}, {31'd0, mem_req}, 32'd0);
      check({tag, " unal wb"}, {31'd0, wb_en}, 32'd0);
    end else if (is_mem) begin
      check({tag, " we"}, {31'd0, mem_we}, {31'd0, !is_ld});
      if (!is_ld) check({tag, " wdata"}, mem_wdata, md);
      n = 0;
      while (mem_req === 1'b1 && n <= TMO + 2) begin
        check({tag, " addr"}, mem_addr, addr);
        check({tag, " mem rdy"}, {31'd0, in_ready}, 32'd0);
        if (n == ack_wait) begin
          mem_ack = 1'b1; mem_rdata = rdv;
        end
        @(negedge clk);
        mem_ack = 1'b0;
        n++;
      end
      check({tag, " req drop"}, {31'd0, mem_req}, 32'd0);
      if (ack_wait >= 0 && ack_wait < TMO) begin
        check({tag, " req cycles"}, n, ack_wait + 1);
        check({tag, " mem wb"}, {31'd0, wb_en}, {31'd0, is_ld && ra != 5'd0});
        if (is_ld && ra != 5'd0) begin
          check({tag, " wb addr"}, {27'd0, wb_addr}, {27'd0, ra});
          check({tag, " wb data"}, wb_data, rdv);
        end
      end else begin
        exp_err = 1'b1;
        check({tag, " tmo cycles"}, n, TMO);
        check({tag, " tmo wb"}, {31'd0, wb_en}, 32'd0);
      end
    end else if ((f & F_JMP) != 8'd0) begin
      check({tag, " br"}, {31'd0, br_taken}, 32'd1);
      check({tag, " target"}, br_target, addr);
      check({tag, " br wb"}, {31'd0, wb_en}, 32'd0);
    end else begin
      check({tag, " br none"}, {31'd0, br_taken}, 32'd0);
      if ((f & F_WR) != 8'd0 && ra != 5'd0) begin
        check({tag, " wb"}, {31'd0, wb_en}, 32'd1);
        check({tag, " wb addr"}, {27'd0, wb_addr}, {27'd0, ra});
        check({tag, " wb data"}, wb_data, res);
      end else begin
        check({tag, " no wb"}, {31'd0, wb_en}, 32'd0);
      end
      check({tag, " ready back"}, {31'd0, in_ready}, 32'd1);
    end
    check({tag, " err"}, {31'd0, mem_err}, {31'd0, exp_err});
    @(negedge clk);
    check({tag, " wb pulse"}, {31'd0, wb_en}, 32'd0);
    check({tag, " br pulse"}, {31'd0, br_taken}, 32'd0);
  endtask

  initial begin
    logic [4:0] rm;
    logic [7:0] rf;
    int k;
    #12;
    check("rst ready", {31'd0, in_ready}, 32'd1);
    check("rst req", {31'd0, mem_req}, 32'd0);
    check("rst outs", {mem_we, wb_en, br_taken, mem_err}, 32'd0);
    check("rst addr", mem_addr | mem_wdata | wb_data | br_target, 32'd0);
    check("rst wb_addr", {27'd0, wb_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("add", 32'd5, 32'd7, 5'b00000, F_CAL | F_WR, 5'd3, 32'd0, 32'd0, 0, 1'b0);
    do_op("sra", 32'h80000000, 32'd4, 5'b01100, F_CAL | F_WR, 5'd4, 32'd0, 32'd0, 0, 1'b0);
    do_op("sub", 32'd1, 32'd2, 5'b00001, F_CAL | F_WR, 5'd5, 32'd0, 32'd0, 0, 1'b0);
    do_op("slt", 32'hFFFFFFFF, 32'd1, 5'd0, F_CMPS | F_WR, 5'd6, 32'd0, 32'd0, 0, 1'b0);
    do_op("sltu", 32'hFFFFFFFF, 32'd1, 5'd0, F_CMP | F_WR, 5'd6, 32'd0, 32'd0, 0, 1'b0);
    do_op("lui", 32'd0, 32'd0, 5'd0, F_LUI | F_WR, 5'd8, 32'h12345000, 32'd0, 0, 1'b0);
    do_op("load", 32'h100, 32'd8, 5'd0, F_LD, 5'd7, 32'd0, 32'd0, 3, 1'b0);
    do_op("store", 32'h200, 32'd4, 5'd0, F_ST, 5'd0, 32'd0, 32'hCAFEF00D, 1, 1'b0);
    do_op("beq", 32'h40, 32'h10, 5'b00001, F_CAL | F_JMP, 5'd0, 32'd0, 32'd0, 0, 1'b0);
    do_op("bnt", 32'h40, 32'h10, 5'b00001, F_CAL, 5'd0, 32'd0, 32'd0, 0, 1'b0);
    do_op("r0", 32'd9, 32'd9, 5'b00000, F_CAL | F_WR, 5'd0, 32'd0, 32'd0, 0, 1'b0);
    do_op("flush", 32'd9, 32'd9, 5'b00000, F_CAL | F_WR, 5'd2, 32'd0, 32'd0, 0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 3);
      rm = 5'($urandom());
      case (k)
        0: rf = F_CAL | F_WR;
        1: rf = (($urandom_range(0, 1) != 0) ? F_CMP : F_CMPS) | F_WR;
        2: rf = F_CAL | (($urandom_range(0, 1) != 0) ? F_JMP : 8'd0);
        default: rf = ($urandom_range(0, 1) != 0) ? F_LD : F_ST;
      endcase
      if (k == 3)
        do_op("rnd mem", $urandom() & 32'hFFFFFFFC, $urandom() & 32'hFFFFFFFC, rm, rf,
              5'($urandom()), 32'd0, $urandom(), $urandom_range(0, 4), 1'b0);
      else
        do_op("rnd op", $urandom(), $urandom(), rm, rf, 5'($urandom()), $urandom(),
              32'd0, 0, 1'b0);
    end

    do_op("unal", 32'h100, 32'd2, 5'd0, F_LD, 5'd7, 32'd0, 32'd0, 0, 1'b0);
    do_op("tmo", 32'h100, 32'd0, 5'd0, F_LD, 5'd7, 32'd0, 32'd0, -1, 1'b0);

    // Reset in the middle of an outstanding load.
    @(negedge clk);
    cal_A = 32'h300; cal_B = 32'd0; reg_address = 5'd9;
    {cal, cmp, cmp_signed, load, store, jump, lui, write_reg} = F_LD;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("mid req", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst req", {31'd0, mem_req}, 32'd0);
    check("arst outs", {mem_we, wb_en, br_taken, mem_err}, 32'd0);
    check("arst addr", mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_err = 1'b0;
    @(negedge clk);
    check("arst wb", {31'd0, wb_en}, 32'd0);
    do_op("post", 32'd20, 32'd22, 5'b00000, F_CAL | F_WR, 5'd1, 32'd0, 32'd0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
